// File: rtl/router_output_ctrl_pkg.sv
// Shared router definitions: default flit width and virtual-channel encoding.
// Used by both the input and the output controllers of the ring router.
package router_pkg;

  localparam int ROUTER_DATA_W = 64;

  typedef logic vc_t;

  localparam vc_t VC_EVEN = 1'b0;
  localparam vc_t VC_ODD  = 1'b1;

  // polarity=1 puts the even VC on the link and lets the switch fill the odd one
  function automatic vc_t txVcOf(input logic polarity);
    return polarity ? VC_EVEN : VC_ODD;
  endfunction

  function automatic vc_t wrVcOf(input logic polarity);
    return polarity ? VC_ODD : VC_EVEN;
  endfunction

endpackage

// File: rtl/router_output_ctrl_if.sv
// Switch-side and link-side handshake bundle of the router output controller.
// master = switch/link environment, slave = the output controller itself.
interface router_output_ctrl_if
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W
);

  logic              req;
  logic [DATA_W-1:0] di;
  logic              ack;
  logic              so;
  logic              ro;
  logic [DATA_W-1:0] dout;

  modport master (output req, di, ro, input ack, so, dout);
  modport slave  (input req, di, ro, output ack, so, dout);

endinterface

// File: rtl/router_output_ctrl_vc_buf.sv
// One-entry virtual-channel buffer: EMPTY <-> FULL, contents kept after a read.
module router_vc_buf
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] di_i,
  input  logic              rd_i,
  output logic              full_o,
  output logic [DATA_W-1:0] dout_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next state: a read empties the slot, a write fills it (never both in practice)
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (rd_i) begin
      full_d = 1'b0;
    end
    if (wr_i) begin
      full_d = 1'b1;
      data_d = di_i;
    end
  end

  // State register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign dout_o = data_q;

endmodule

// File: rtl/router_output_ctrl.sv
// Router output-port controller: two one-entry VC buffers, the switch writes
// one VC while the link drains the other, selected by the global polarity.
// Optional statistics counters are enabled with `define ROUTER_OUT_STATS_EN.
module router_output_ctrl
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  router_output_ctrl_if.slave   bus
`ifdef ROUTER_OUT_STATS_EN
  ,
  output logic [CNT_W-1:0]      sent_cnt,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  vc_t               txVc;
  vc_t               wrVc;
  logic              fullEven;
  logic              fullOdd;
  logic [DATA_W-1:0] dataEven;
  logic [DATA_W-1:0] dataOdd;
  logic              txFull;
  logic              wrFull;
  logic [DATA_W-1:0] txData;
  logic              accept;
  logic              deliver;
  logic              sendOut;

  assign txVc = txVcOf(polarity);
  assign wrVc = wrVcOf(polarity);

  // Handshake muxing: everything is combinational from buffer state, polarity and req
  always_comb begin
    txFull  = (txVc == VC_EVEN) ? fullEven : fullOdd;
    wrFull  = (wrVc == VC_EVEN) ? fullEven : fullOdd;
    txData  = (txVc == VC_EVEN) ? dataEven : dataOdd;
    accept  = bus.req & ~reset & ~wrFull;
    sendOut = ~reset & txFull;
    deliver = sendOut & bus.ro;
  end

  assign bus.ack  = accept;
  assign bus.so   = sendOut;
  assign bus.dout = reset ? '0 : txData;

  router_vc_buf #(.DATA_W(DATA_W)) uEvenBuf (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (accept & (wrVc == VC_EVEN)),
    .di_i   (bus.di),
    .rd_i   (deliver & (txVc == VC_EVEN)),
    .full_o (fullEven),
    .dout_o (dataEven)
  );

  router_vc_buf #(.DATA_W(DATA_W)) uOddBuf (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (accept & (wrVc == VC_ODD)),
    .di_i   (bus.di),
    .rd_i   (deliver & (txVc == VC_ODD)),
    .full_o (fullOdd),
    .dout_o (dataOdd)
  );

`ifdef ROUTER_OUT_STATS_EN
  logic [CNT_W-1:0] sentCnt_q, sentCnt_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  // Saturating link statistics: delivered flits and back-pressured cycles
  always_comb begin
    sentCnt_d  = sentCnt_q;
    stallCnt_d = stallCnt_q;
    if (deliver && (sentCnt_q != {CNT_W{1'b1}})) begin
      sentCnt_d = sentCnt_q + 1'b1;
    end
    if (sendOut && !bus.ro && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sentCnt_q  <= '0;
      stallCnt_q <= '0;
    end else begin
      sentCnt_q  <= sentCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign sent_cnt  = sentCnt_q;
  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_router_output_ctrl.sv
// Scoreboard bench for router_output_ctrl: the driver predicts each cycle's
// outputs from a queue-per-VC model, the monitor pops and compares at negedge.
module tb_router_output_ctrl;

  localparam int DW = 64;
  localparam int CW = 16;

  typedef struct {
    logic          ack;
    logic          so;
    logic [DW-1:0] dout;
    logic          chkDout;
    logic [CW-1:0] sent;
    logic [CW-1:0] stall;
  } exp_t;

  logic clk;
  logic reset;
  logic polarity;

  router_output_ctrl_if #(.DATA_W(DW)) bus ();

`ifdef ROUTER_OUT_STATS_EN
  logic [CW-1:0] sent_cnt;
  logic [CW-1:0] stall_cnt;
`endif

  router_output_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .bus       (bus.slave)
`ifdef ROUTER_OUT_STATS_EN
    ,
    .sent_cnt  (sent_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  exp_t          expQ[$];
  logic [DW-1:0] evenQ[$];
  logic [DW-1:0] oddQ[$];
  logic [CW-1:0] sentM;
  logic [CW-1:0] stallM;
  int            testCount;
  int            failCount;
  bit            driveDone;
  bit            monDone;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, predict the outputs from the VC queues, then advance the model
  task automatic applyStimulus(input bit rst, input bit rq, input logic [DW-1:0] d, input bit r);
    exp_t e;
    bit   txEven;
    bit   txHas;
    bit   wrHas;
    @(posedge clk);
    #1;
    polarity = ~polarity;
    reset    = rst;
    bus.req  = rq;
    bus.di   = d;
    bus.ro   = r;
    e.sent   = sentM;
    e.stall  = stallM;
    if (rst) begin
      e.ack     = 1'b0;
      e.so      = 1'b0;
      e.dout    = '0;
      e.chkDout = 1'b1;
      evenQ.delete();
      oddQ.delete();
      sentM  = '0;
      stallM = '0;
    end else begin
      txEven    = polarity;
      txHas     = txEven ? (evenQ.size() != 0) : (oddQ.size() != 0);
      wrHas     = txEven ? (oddQ.size() != 0) : (evenQ.size() != 0);
      e.ack     = rq && !wrHas;
      e.so      = txHas;
      e.chkDout = txHas;
      e.dout    = '0;
      if (txHas) e.dout = txEven ? evenQ[0] : oddQ[0];
      if (txHas && r) begin
        if (txEven) void'(evenQ.pop_front());
        else        void'(oddQ.pop_front());
        if (sentM != '1) sentM = sentM + 1'b1;
      end else if (txHas) begin
        if (stallM != '1) stallM = stallM + 1'b1;
      end
      if (e.ack) begin
        if (txEven) oddQ.push_back(d);
        else        evenQ.push_back(d);
      end
    end
    expQ.push_back(e);
  endtask

  // Insert an idle cycle if needed so the next stimulus cycle sees polarity p
  task automatic alignPolarity(input bit p);
    if ((~polarity) != p) applyStimulus(0, 0, '0, 1);
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    testCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one prediction per cycle, compared half a cycle after the drive
  initial begin
    exp_t e;
    monDone = 1'b0;
    while (!driveDone || expQ.size() != 0) begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("ack", {63'b0, bus.ack}, {63'b0, e.ack});
        checkOutput("so", {63'b0, bus.so}, {63'b0, e.so});
        if (e.chkDout) checkOutput("dout", bus.dout, e.dout);
`ifdef ROUTER_OUT_STATS_EN
        checkOutput("sent_cnt", {48'b0, sent_cnt}, {48'b0, e.sent});
        checkOutput("stall_cnt", {48'b0, stall_cnt}, {48'b0, e.stall});
`endif
      end
    end
    monDone = 1'b1;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [DW-1:0] cnt;
    testCount = 0;
    failCount = 0;
    driveDone = 1'b0;
    sentM     = '0;
    stallM    = '0;
    polarity  = 1'b0;
    reset     = 1'b1;
    bus.req   = 1'b0;
    bus.di    = '0;
    bus.ro    = 1'b0;

    // reset held with req and ro high
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 64'hDEAD_BEEF_0000_0000 + 64'(i), 1);

    // single flit written on even VC, sent next cycle
    alignPolarity(0);
    applyStimulus(0, 1, 64'hA5A5_0000_0000_0001, 1);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);

    // back-pressure for four cycles, then delivery
    applyStimulus(1, 0, '0, 1);
    alignPolarity(0);
    applyStimulus(0, 1, 64'h1234_5678_9ABC_DEF0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);

    // both VCs full: requests refused, buffers untouched
    alignPolarity(0);
    applyStimulus(0, 1, 64'hEEEE_0000_0000_0000, 0);
    applyStimulus(0, 1, 64'h0DD0_0000_0000_0000, 0);
    applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    applyStimulus(0, 1, 64'h0000_0000_0000_0000, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1);

    // streaming with counter data
    cnt = 64'd100;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, cnt, 1);
      cnt = cnt + 1;
    end

    // reset while the odd VC is on the link
    alignPolarity(1);
    applyStimulus(0, 1, 64'h0DDF_1A70_0000_0006, 0);
    applyStimulus(1, 1, 64'h0000_0000_0000_0007, 0);
    applyStimulus(0, 1, 64'h0000_0000_0000_0008, 1);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0),
                    {$urandom, $urandom},
                    ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1);

    driveDone = 1'b1;
    for (int i = 0; i < 10 && !monDone; i++) @(negedge clk);
    if (!monDone) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
